// File: rtl/mux21_pkg.sv
// Shared definitions for the two-source round-robin arbiter in front of the 2:1 data mux.
package mux21_pkg;

  localparam int unsigned W_DEF    = 8;
  localparam int unsigned MAXB_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  // Grant state for a given source index.
  function automatic state_t grant_of(input logic k);
    return k ? G1 : G0;
  endfunction

endpackage

// File: rtl/mux21b.sv
// Plain 2:1 data mux; select 0 passes a, select 1 passes b.
module mux21b #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         s,
  output logic [W-1:0] y
);

  assign y = s ? b : a;

endmodule

// File: rtl/mux21_arb.sv
// Round-robin packet arbiter owning the select of a shared 2:1 mux; holds a grant
// until the last beat and forces release when a packet runs past MAXB beats.
module mux21_arb
  import mux21_pkg::*;
#(
  parameter int unsigned W    = W_DEF,
  parameter int unsigned MAXB = MAXB_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic         v0,
  input  logic         v1,
  input  logic         l0,
  input  logic         l1,
  output logic         r0,
  output logic         r1,
  output logic [W-1:0] y,
  output logic         yv,
  output logic         yl,
  input  logic         yr,
  output logic         s,
  output logic         busy,
  output logic         err
);

  localparam int unsigned BCW = $clog2(MAXB) + 1;

  state_t         state;
  logic           p;
  logic [BCW-1:0] bc;
  logic [BCW-1:0] bc_nxt;
  logic [W-1:0]   y_mux;
  logic           k;
  logic           vk;
  logic           vo;
  logic           lk;
  logic           hs;
  logic           over;
  logic           eop;

  assign busy = (state != IDLE);
  assign s    = (state == G1);
  assign k    = s;

  // Granted source's handshake signals; the other source is locked out.
  assign vk = k ? v1 : v0;
  assign vo = k ? v0 : v1;
  assign lk = k ? l1 : l0;
  assign hs = busy & vk & yr;

  // Forced end of packet when the limit is hit without a last flag.
  assign bc_nxt = bc + BCW'(1);
  assign over   = hs & ~lk & (bc_nxt == BCW'(MAXB));
  assign eop    = (hs & lk) | over;

  mux21b #(.W(W)) u_mux (
    .a (d0),
    .b (d1),
    .s (s),
    .y (y_mux)
  );

  assign y  = busy ? y_mux : '0;
  assign yv = busy & vk;
  assign yl = busy & lk;
  assign r0 = (state == G0) & yr;
  assign r1 = (state == G1) & yr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      p     <= 1'b0;
      bc    <= '0;
      err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          bc <= '0;
          if (v0 && v1)  state <= grant_of(p);
          else if (v0)   state <= G0;
          else if (v1)   state <= G1;
        end
        G0, G1: begin
          if (eop) begin
            p  <= ~k;
            bc <= '0;
            if (over) err <= 1'b1;
            if (vo)       state <= grant_of(~k);
            else if (vk)  state <= grant_of(k);
            else          state <= IDLE;
          end else if (hs) begin
            bc <= bc_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux21_arb.sv
// Scoreboard bench for mux21_arb: expected beats are queued as sources drive them
// and compared when the output handshake fires.
module tb_mux21_arb;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       src;
  } beat_t;

  logic       clk;
  logic       rst;
  logic [7:0] d0, d1, y;
  logic       v0, v1, l0, l1, r0, r1, yv, yl, yr, s, busy, err;

  beat_t sb[$];
  beat_t e;
  int    n_checks;
  int    n_pass;

  mux21_arb #(.W(8), .MAXB(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .d0   (d0),
    .d1   (d1),
    .v0   (v0),
    .v1   (v1),
    .l0   (l0),
    .l1   (l1),
    .r0   (r0),
    .r1   (r1),
    .y    (y),
    .yv   (yv),
    .yl   (yl),
    .yr   (yr),
    .s    (s),
    .busy (busy),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; l0 = 1'b0; l1 = 1'b0;
    d0 = 8'h00; d1 = 8'h00; yr = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++;
    if ({busy, s, yv, r0, r1, yl, err} !== 7'b0)
      $display("FAIL reset_ctrl: got %b want 0000000", {busy, s, yv, r0, r1, yl, err});
    else n_pass++;
    n_checks++;
    if (y !== 8'h00) $display("FAIL reset_y: got %h want 00", y);
    else n_pass++;
  endtask

  task automatic test_single();
    do_reset();
    v0 = 1'b1; d0 = 8'hA5; l0 = 1'b1; yr = 1'b1;
    sb.push_back('{d: 8'hA5, l: 1'b1, src: 1'b0});
    @(negedge clk);
    n_checks++;
    if ({busy, yv} !== 2'b00) $display("FAIL single_latency: got busy,yv=%b want 00", {busy, yv});
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({busy, s, yv, r0, r1} !== 5'b10110)
      $display("FAIL single_grant: got %b want 10110", {busy, s, yv, r0, r1});
    else n_pass++;
    n_checks++;
    if (!(yv && yr)) $display("FAIL single_hs: got no handshake want handshake");
    else if (sb.size() == 0) $display("FAIL single_beat: got y=%h want nothing", y);
    else begin
      e = sb.pop_front();
      if ({y, yl, s} !== {e.d, e.l, e.src})
        $display("FAIL single_beat: got %h/%b/%b want %h/%b/%b", y, yl, s, e.d, e.l, e.src);
      else n_pass++;
    end
    @(posedge clk); #1;
    v0 = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({err, yv, sb.size() == 0} !== 3'b001)
      $display("FAIL single_after: got err,yv,empty=%b want 001", {err, yv, sb.size() == 0});
    else n_pass++;
  endtask

  task automatic test_alternate();
    do_reset();
    v0 = 1'b1; v1 = 1'b1; l0 = 1'b1; l1 = 1'b1; yr = 1'b1;
    d0 = 8'h10; d1 = 8'h20;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      d0 = 8'(16 + i);
      d1 = 8'(32 + i);
      sb.push_back('{d: (i[0] ? d1 : d0), l: 1'b1, src: i[0]});
      @(negedge clk);
      n_checks++;
      if ({yv, s} !== {1'b1, i[0]}) $display("FAIL alt_sel%0d: got yv,s=%b want 1%b", i, {yv, s}, i[0]);
      else n_pass++;
      n_checks++;
      if (!(yv && yr)) $display("FAIL alt_hs%0d: got no handshake want handshake", i);
      else if (sb.size() == 0) $display("FAIL alt_beat%0d: got y=%h want nothing", i, y);
      else begin
        e = sb.pop_front();
        if ({y, yl, s} !== {e.d, e.l, e.src})
          $display("FAIL alt_beat%0d: got %h/%b/%b want %h/%b/%b", i, y, yl, s, e.d, e.l, e.src);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    v0 = 1'b0; v1 = 1'b0;
    n_checks++;
    if (sb.size() != 0) $display("FAIL alt_drain: got %0d left want 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_hold();
    do_reset();
    v0 = 1'b1; d0 = 8'h40; l0 = 1'b0; yr = 1'b1;
    @(posedge clk); #1;
    for (int b = 0; b < 4; b++) begin
      d0 = 8'(64 + b); l0 = (b == 3); v1 = (b >= 1); d1 = 8'h77; l1 = 1'b1;
      sb.push_back('{d: d0, l: l0, src: 1'b0});
      @(negedge clk);
      n_checks++;
      if ({r0, r1, s} !== 3'b100) $display("FAIL hold_lock%0d: got r0,r1,s=%b want 100", b, {r0, r1, s});
      else n_pass++;
      n_checks++;
      if (!(yv && yr)) $display("FAIL hold_hs%0d: got no handshake want handshake", b);
      else if (sb.size() == 0) $display("FAIL hold_beat%0d: got y=%h want nothing", b, y);
      else begin
        e = sb.pop_front();
        if ({y, yl, s} !== {e.d, e.l, e.src})
          $display("FAIL hold_beat%0d: got %h/%b/%b want %h/%b/%b", b, y, yl, s, e.d, e.l, e.src);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    v0 = 1'b0;
    sb.push_back('{d: 8'h77, l: 1'b1, src: 1'b1});
    @(negedge clk);
    n_checks++;
    if ({busy, s, r0} !== 3'b110) $display("FAIL hold_switch: got busy,s,r0=%b want 110", {busy, s, r0});
    else n_pass++;
    n_checks++;
    if (!(yv && yr)) $display("FAIL hold_hs_g1: got no handshake want handshake");
    else begin
      e = sb.pop_front();
      if ({y, yl, s} !== {e.d, e.l, e.src})
        $display("FAIL hold_beat_g1: got %h/%b/%b want %h/%b/%b", y, yl, s, e.d, e.l, e.src);
      else n_pass++;
    end
    @(posedge clk); #1;
    v1 = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    v1 = 1'b1; d1 = 8'h90; l1 = 1'b0; yr = 1'b1;
    @(posedge clk); #1;
    for (int b = 0; b < 7; b++) begin
      yr = !(b >= 1 && b <= 3);
      d1 = 8'(144 + ((b < 1) ? 0 : (b <= 3) ? 1 : b - 2));
      l1 = (b == 6);
      if (yr) sb.push_back('{d: d1, l: l1, src: 1'b1});
      @(negedge clk);
      if (!yr) begin
        n_checks++;
        if ({yv, yl, r1, s, y} !== {4'b1001, 8'h91})
          $display("FAIL stall_held%0d: got %b/%h want 1001/91", b, {yv, yl, r1, s}, y);
        else n_pass++;
      end else begin
        n_checks++;
        if (!(yv && yr)) $display("FAIL stall_hs%0d: got no handshake want handshake", b);
        else if (sb.size() == 0) $display("FAIL stall_beat%0d: got y=%h want nothing", b, y);
        else begin
          e = sb.pop_front();
          if ({y, yl, s} !== {e.d, e.l, e.src})
            $display("FAIL stall_beat%0d: got %h/%b/%b want %h/%b/%b", b, y, yl, s, e.d, e.l, e.src);
          else n_pass++;
        end
      end
      @(posedge clk); #1;
    end
    v1 = 1'b0; yr = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({err, sb.size() == 0} !== 2'b01) $display("FAIL stall_err: got err,empty=%b want 01", {err, sb.size() == 0});
    else n_pass++;
  endtask

  task automatic test_maxb();
    do_reset();
    v1 = 1'b1; l1 = 1'b0; d1 = 8'hC0; yr = 1'b1; d0 = 8'h55; l0 = 1'b1;
    @(posedge clk); #1;
    for (int b = 0; b < 7; b++) begin
      v0 = (b >= 1 && b <= 4);
      d1 = 8'(192 + b);
      sb.push_back((b == 4) ? '{d: 8'h55, l: 1'b1, src: 1'b0} : '{d: d1, l: 1'b0, src: 1'b1});
      @(negedge clk);
      n_checks++;
      if (err !== (b >= 4)) $display("FAIL maxb_err%0d: got %b want %b", b, err, (b >= 4));
      else n_pass++;
      n_checks++;
      if (!(yv && yr)) $display("FAIL maxb_hs%0d: got no handshake want handshake", b);
      else if (sb.size() == 0) $display("FAIL maxb_beat%0d: got y=%h want nothing", b, y);
      else begin
        e = sb.pop_front();
        if ({y, yl, s} !== {e.d, e.l, e.src})
          $display("FAIL maxb_beat%0d: got %h/%b/%b want %h/%b/%b", b, y, yl, s, e.d, e.l, e.src);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    v0 = 1'b0; v1 = 1'b0;
    do_reset();
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0) $display("FAIL maxb_clear: got err=%b want 0", err);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    v0 = 1'b1; d0 = 8'h30; l0 = 1'b1; yr = 1'b1;
    @(posedge clk); #1;
    for (int b = 0; b < 2; b++) begin
      d0 = 8'(48 + b); l0 = (b == 0);
      sb.push_back('{d: d0, l: l0, src: 1'b0});
      @(negedge clk);
      n_checks++;
      if (!(yv && yr)) $display("FAIL mid_hs%0d: got no handshake want handshake", b);
      else begin
        e = sb.pop_front();
        if ({y, yl, s} !== {e.d, e.l, e.src})
          $display("FAIL mid_beat%0d: got %h/%b/%b want %h/%b/%b", b, y, yl, s, e.d, e.l, e.src);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    rst = 1'b1; d0 = 8'h32;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({yv, r0, s, busy} !== 4'b0000) $display("FAIL mid_idle: got yv,r0,s,busy=%b want 0000", {yv, r0, s, busy});
    else n_pass++;
    rst = 1'b0; v1 = 1'b1; l0 = 1'b1; l1 = 1'b1; d0 = 8'hE0; d1 = 8'hE1;
    @(posedge clk); #1;
    sb.push_back('{d: 8'hE0, l: 1'b1, src: 1'b0});
    @(negedge clk);
    n_checks++;
    if (!(yv && yr)) $display("FAIL mid_ptr_hs: got no handshake want handshake");
    else begin
      e = sb.pop_front();
      if ({y, yl, s} !== {e.d, e.l, e.src})
        $display("FAIL mid_ptr: got %h/%b/%b want %h/%b/%b", y, yl, s, e.d, e.l, e.src);
      else n_pass++;
    end
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; l0 = 1'b0; l1 = 1'b0;
    d0 = 8'h00; d1 = 8'h00; yr = 1'b1;
    test_reset();
    test_single();
    test_alternate();
    test_hold();
    test_stall();
    test_maxb();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
